br_resolve: RTL
===============

// Module: br_resolve
// PURPOSE
//   Consumer end of the pre-decode prediction interface. Queues one prediction record per
//   pre-decoded branch/jump in IF and pops the oldest record when EX resolves that branch.
//   Compares predicted and actual next-fetch PC after the delay slot. On mismatch, issues a
//   registered one-cycle redirect to fetch and discards every younger (wrong-path) record.
// PARAMETERS
//   DEPTH   4   prediction queue entries (power of 2, >=2)
//   PTR_W   2   log2(DEPTH)
// PORTS
//   clk             in   1   core clock, all state on rising edge
//   resetn          in   1   asynchronous active-low reset
//   flush           in   1   exception/eret flush; clears queue, cancels redirect
//   pd_valid        in   1   push: pre-decoded branch/jump leaving IF this cycle
//   pd_pc           in   32  PC of the branch instruction
//   pd_take         in   1   fetch predicted/forced taken
//   pd_target_ok    in   1   pd_target is valid (0 for jr/jalr)
//   pd_target       in   32  predicted target
//   push_ready      out  1   queue not full (= !full, no pop look-ahead)
//   ex_valid        in   1   pop: oldest queued branch resolved in EX this cycle
//   ex_taken        in   1   actual direction
//   ex_target       in   32  actual target (branch or register target)
//   resolve_ready   out  1   queue not empty
//   redirect        out  1   one-cycle pulse: refetch from redirect_pc
//   redirect_pc     out  32  correct next-fetch PC
//   stat_resolved   out  32  resolved-branch count (BR_STAT_EN)
//   stat_mispred    out  32  mispredict count (BR_STAT_EN)
// BEHAVIOUR
//   - Reset: queue empty (rd_ptr=wr_ptr=0, count=0), redirect=0, redirect_pc=0, stats=0,
//     push_ready=1, resolve_ready=0.
//   - Queue: circular, PTR_W-bit pointers wrap DEPTH-1 -> 0, count is PTR_W+1 bits.
//     Entry = {pc, take, target_ok, target}.
//   - Push accepted iff pd_valid && push_ready. pd_valid while full: dropped, no state change.
//   - Pop iff ex_valid && resolve_ready. ex_valid while empty: ignored, no redirect.
//   - Per popped entry e: fall = e.pc + 8 (branch + delay slot, 32-bit wrap).
//     pred_next = (e.take && e.target_ok) ? e.target : fall.
//     act_next = ex_taken ? ex_target : fall.
//     Entries with take=1, target_ok=0 (jr/jalr) mispredict unconditionally.
//     mispredict = (pred_next != act_next) || (e.take && !e.target_ok).
//   - Mispredict: next edge redirect=1, redirect_pc=act_next. Queue cleared in that edge,
//     including any push in the same cycle (wrong path). redirect low the following cycle
//     unless another mispredict.
//   - Correct prediction: entry popped. Same-cycle push proceeds normally. Push+pop when
//     full: pop frees a slot, but the push is still refused because push_ready was 0.
//   - Latency: resolve -> redirect exactly 1 cycle. Push -> poppable the next cycle.
//   - flush: highest priority. Next edge: queue empty, redirect=0, same-cycle push/pop
//     discarded, no stat update for that pop.
//   - Async resetn low mid-operation: all state to reset values immediately.
//   - redirect_pc holds its last value when redirect=0.
// CONFIGURATION
//   BR_STAT_EN defined: stat_resolved increments on each non-flushed pop. stat_mispred
//     increments on each mispredict. Both 32-bit wrap, cleared only by resetn.
//   BR_STAT_EN undefined: counters not built. stat_resolved and stat_mispred tied to 0.
// TESTING
//   1 push pc=0xBFC00010 take=1 ok=1 tgt=0xBFC00100; resolve taken tgt=0xBFC00100 ->
//     no redirect, queue empty.
//   2 push pc=0x80000020 take=0; resolve taken tgt=0x80000400 -> next cycle redirect=1,
//     redirect_pc=0x80000400.
//   3 push pc=0x80000040 take=1 ok=0 (jr); resolve tgt=0x80001234 ->
//     redirect_pc=0x80001234 although ex_target matches nothing predicted.
//   4 push 4 entries -> push_ready=0; 5th push dropped. Mispredict on first pop ->
//     queue empty, resolve_ready=0 next cycle.
//   5 flush with ex_valid mispredict and pd_valid in same cycle -> redirect=0, queue empty,
//     stats unchanged.
//   6 BR_STAT_EN: 3 resolves, 1 mispredict -> stat_resolved=3, stat_mispred=1.
//     Without macro both read 0.

Source files
------------

// File: rtl/br_resolve_if.sv
// br_resolve_if: prediction-queue bus between fetch/EX (master) and br_resolve (slave).
// Carries push side (pd_*), resolve side (ex_*), redirect and statistics.
//   pd_valid/pd_pc/pd_take/pd_target_ok/pd_target -> push_ready
//   ex_valid/ex_taken/ex_target                   -> resolve_ready
//   redirect/redirect_pc                          -> refetch request
//   stat_resolved/stat_mispred                    -> counters (BR_STAT_EN)
interface br_resolve_if;
   logic        pd_valid;
   logic [31:0] pd_pc;
   logic        pd_take;
   logic        pd_target_ok;
   logic [31:0] pd_target;
   logic        push_ready;
   logic        ex_valid;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        resolve_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] stat_resolved;
   logic [31:0] stat_mispred;

   modport master (
      output pd_valid, pd_pc, pd_take, pd_target_ok, pd_target,
      output ex_valid, ex_taken, ex_target,
      input  push_ready, resolve_ready,
      input  redirect, redirect_pc,
      input  stat_resolved, stat_mispred
   );

   modport slave (
      input  pd_valid, pd_pc, pd_take, pd_target_ok, pd_target,
      input  ex_valid, ex_taken, ex_target,
      output push_ready, resolve_ready,
      output redirect, redirect_pc,
      output stat_resolved, stat_mispred
   );
endinterface

// File: rtl/br_resolve.sv
// br_resolve: queues pre-decoded branch predictions from IF, checks them at EX
// resolve and issues a registered one-cycle redirect on mispredict.
// Ports: clk, resetn (async active-low), flush, bif (br_resolve_if.slave).
// Optional macro BR_STAT_EN builds the resolved/mispredict counters.
module br_resolve #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic        clk,
   input logic        resetn,
   input logic        flush,
   br_resolve_if.slave bif
);

   typedef struct packed {
      logic [31:0] pc;
      logic        take;
      logic        target_ok;
      logic [31:0] target;
   } entry_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             redirect_q;
   logic [31:0]      redirect_pc_q;

   logic             full;
   logic             empty;
   logic             push_ok;
   logic             pop_ok;
   entry_t           head;
   logic [31:0]      fall;
   logic [31:0]      pred_next;
   logic [31:0]      act_next;
   logic             mispred;
   logic             enq;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign bif.push_ready    = !full;
   assign bif.resolve_ready = !empty;
   assign bif.redirect      = redirect_q;
   assign bif.redirect_pc   = redirect_pc_q;

   assign push_ok = bif.pd_valid && !full;
   assign pop_ok  = bif.ex_valid && !empty;

   assign head = mem[rd_ptr];

   // Next-fetch PC after branch and its delay slot.
   always_comb begin
      fall      = head.pc + 32'd8;
      pred_next = fall;
      act_next  = fall;
      if (head.take && head.target_ok)
         pred_next = head.target;
      if (bif.ex_taken)
         act_next = bif.ex_target;
   end

   // Register-target jumps never carry a usable target, so they always refetch.
   assign mispred = pop_ok &&
                    ((pred_next != act_next) ||
                     (head.take && !head.target_ok));

   // A mispredict squashes any same-cycle push as wrong-path.
   assign enq = push_ok && !flush && !mispred;

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr].pc        <= bif.pd_pc;
         mem[wr_ptr].take      <= bif.pd_take;
         mem[wr_ptr].target_ok <= bif.pd_target_ok;
         mem[wr_ptr].target    <= bif.pd_target;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         redirect_q <= 1'b0;
      end else if (mispred) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         redirect_q    <= 1'b1;
         redirect_pc_q <= act_next;
      end else begin
         redirect_q <= 1'b0;
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef BR_STAT_EN
   logic [31:0] stat_res_q;
   logic [31:0] stat_mis_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else if (!flush) begin
         if (pop_ok)
            stat_res_q <= stat_res_q + 32'd1;
         if (mispred)
            stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign bif.stat_resolved = stat_res_q;
   assign bif.stat_mispred  = stat_mis_q;
`else
   assign bif.stat_resolved = '0;
   assign bif.stat_mispred  = '0;
`endif

endmodule
